// File: rtl/wshb_sdram_arbiter.sv
// wshb_sdram_arbiter: shares one SDRAM Wishbone slave port between two masters.
// M0 = video frame reader, M1 = frame writer. Round-robin arbitration; a grant is
// held for the whole Wishbone cycle. Optional stall watchdog: define
// WSHB_ARB_TIMEOUT_EN to abort a granted cycle after TIMEOUT unanswered strobes.
module wshb_sdram_arbiter #(
    parameter int DATA_BYTES = 4,
    parameter int ADR_W      = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    // master 0 (video reader)
    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [ADR_W-1:0]        m0_adr,
    input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
    input  logic [DATA_BYTES-1:0]   m0_sel,
    input  logic [2:0]              m0_cti,
    input  logic [1:0]              m0_bte,
    output logic [8*DATA_BYTES-1:0] m0_dat_sm,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic                    m0_rty,
    // master 1 (frame writer)
    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [ADR_W-1:0]        m1_adr,
    input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
    input  logic [DATA_BYTES-1:0]   m1_sel,
    input  logic [2:0]              m1_cti,
    input  logic [1:0]              m1_bte,
    output logic [8*DATA_BYTES-1:0] m1_dat_sm,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic                    m1_rty,
    // SDRAM slave
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADR_W-1:0]        s_adr,
    output logic [8*DATA_BYTES-1:0] s_dat_ms,
    output logic [DATA_BYTES-1:0]   s_sel,
    output logic [2:0]              s_cti,
    output logic [1:0]              s_bte,
    input  logic [8*DATA_BYTES-1:0] s_dat_sm,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic                    s_rty,
    // one-hot grant {M1,M0}
    output logic [1:0]              gnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT0  = 2'd1,
`ifdef WSHB_ARB_TIMEOUT_EN
        S_GNT1  = 2'd2,
        S_ABORT = 2'd3
`else
        S_GNT1  = 2'd2
`endif
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last;     // 0 = M0 owned the bus last, 1 = M1

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("wshb_sdram_arbiter: TIMEOUT must be at least 1");
    end

    // read data is broadcast; each master qualifies it with its own ack
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;

`ifdef WSHB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    logic [TMO_W-1:0] r_cnt;
    logic             w_term;
    logic             w_stall;

    assign w_term  = s_ack || s_err || s_rty;
    assign w_stall = s_stb && !w_term;

    // watchdog: counts unanswered strobes of the current grant
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state || w_term) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`endif

    // state register and round-robin history
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == S_GNT0) begin
                r_last <= 1'b0;
            end else if (w_next == S_GNT1) begin
                r_last <= 1'b1;
            end
        end
    end

    // next-state: release hands over directly when the other master waits
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    w_next = r_last ? S_GNT0 : S_GNT1;
                end else if (m0_cyc) begin
                    w_next = S_GNT0;
                end else if (m1_cyc) begin
                    w_next = S_GNT1;
                end
            end
            S_GNT0: begin
                if (!m0_cyc) begin
                    w_next = m1_cyc ? S_GNT1 : S_IDLE;
                end
`ifdef WSHB_ARB_TIMEOUT_EN
                else if (w_stall && r_cnt == TMO_W'(TIMEOUT - 1)) begin
                    w_next = S_ABORT;
                end
`endif
            end
            S_GNT1: begin
                if (!m1_cyc) begin
                    w_next = m0_cyc ? S_GNT0 : S_IDLE;
                end
`ifdef WSHB_ARB_TIMEOUT_EN
                else if (w_stall && r_cnt == TMO_W'(TIMEOUT - 1)) begin
                    w_next = S_ABORT;
                end
`endif
            end
`ifdef WSHB_ARB_TIMEOUT_EN
            S_ABORT: w_next = S_IDLE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // bus muxes: slave follows the granted master, terminations go back to it only
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rty   = 1'b0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rty   = 1'b0;
        gnt      = 2'b00;
        case (r_state)
            S_GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_ms = m0_dat_ms;
                s_sel    = m0_sel;
                s_cti    = m0_cti;
                s_bte    = m0_bte;
                m0_ack   = s_ack;
                m0_err   = s_err;
                m0_rty   = s_rty;
                gnt      = 2'b01;
            end
            S_GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_ms = m1_dat_ms;
                s_sel    = m1_sel;
                s_cti    = m1_cti;
                s_bte    = m1_bte;
                m1_ack   = s_ack;
                m1_err   = s_err;
                m1_rty   = s_rty;
                gnt      = 2'b10;
            end
`ifdef WSHB_ARB_TIMEOUT_EN
            S_ABORT: begin
                // slave is released; the stalled master gets a bus error
                if (r_last) begin
                    m1_err = 1'b1;
                end else begin
                    m0_err = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// tb_wshb_sdram_arbiter: directed reset/tie cases, then randomized traffic from two
// masters checked every cycle against a grant-ownership reference model.
// With WSHB_ARB_TIMEOUT_EN defined the stall watchdog (TIMEOUT=16) is also exercised.
module tb_wshb_sdram_arbiter;

    localparam int DB  = 4;
    localparam int AW  = 32;
    localparam int DW  = 8 * DB;
    localparam int TMO = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;

    logic          c   [2];
    logic          st  [2];
    logic          we  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dms [2];
    logic [DB-1:0] sel [2];
    logic [2:0]    cti [2];
    logic [1:0]    bte [2];

    logic [DW-1:0] m0_dat_sm, m1_dat_sm;
    logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_ms;
    logic [DB-1:0] s_sel;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic [DW-1:0] s_dat_sm;
    logic          s_ack, s_err, s_rty;
    logic [1:0]    gnt;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: who owns the bus and who owned it last
    int owner;
    int last;
    int beats [2];
    int gap   [2];
    bit sat;
    bit exp_stb;
    int r;

    wshb_sdram_arbiter #(
        .DATA_BYTES (DB),
        .ADR_W      (AW),
        .TIMEOUT    (TMO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .m0_cyc    (c[0]),   .m0_stb (st[0]),  .m0_we  (we[0]),
        .m0_adr    (adr[0]), .m0_dat_ms (dms[0]), .m0_sel (sel[0]),
        .m0_cti    (cti[0]), .m0_bte (bte[0]),
        .m0_dat_sm (m0_dat_sm), .m0_ack (m0_ack), .m0_err (m0_err), .m0_rty (m0_rty),
        .m1_cyc    (c[1]),   .m1_stb (st[1]),  .m1_we  (we[1]),
        .m1_adr    (adr[1]), .m1_dat_ms (dms[1]), .m1_sel (sel[1]),
        .m1_cti    (cti[1]), .m1_bte (bte[1]),
        .m1_dat_sm (m1_dat_sm), .m1_ack (m1_ack), .m1_err (m1_err), .m1_rty (m1_rty),
        .s_cyc     (s_cyc),  .s_stb (s_stb),   .s_we (s_we),
        .s_adr     (s_adr),  .s_dat_ms (s_dat_ms), .s_sel (s_sel),
        .s_cti     (s_cti),  .s_bte (s_bte),
        .s_dat_sm  (s_dat_sm), .s_ack (s_ack), .s_err (s_err), .s_rty (s_rty),
        .gnt       (gnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] obs_ctrl();
        return {gnt, s_cyc, s_stb, s_we, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty};
    endfunction

    task automatic drive_quiet();
        for (int x = 0; x < 2; x++) begin
            c[x] = 1'b0; st[x] = 1'b0; we[x] = 1'b0;
            adr[x] = '0; dms[x] = '0; sel[x] = '0; cti[x] = '0; bte[x] = '0;
        end
        s_dat_sm = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        drive_quiet();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        owner = -1;
        last  = 1;
        for (int x = 0; x < 2; x++) begin
            beats[x] = 0;
            gap[x]   = 0;
        end
    endtask

    // expected outputs follow directly from who owns the bus this cycle
    task automatic model_check();
        logic [1:0]    eg;
        logic          ecyc, estb, ewe;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic [8:0]    emisc;
        logic [10:0]   ectrl;
        eg = 2'b00; ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
        eadr = '0; edat = '0; emisc = '0;
        if (owner >= 0) begin
            eg    = (owner == 0) ? 2'b01 : 2'b10;
            ecyc  = c[owner];
            estb  = st[owner];
            ewe   = we[owner];
            eadr  = adr[owner];
            edat  = dms[owner];
            emisc = {sel[owner], cti[owner], bte[owner]};
        end
        ectrl = {eg, ecyc, estb, ewe,
                 owner == 0 && s_ack, owner == 0 && s_err, owner == 0 && s_rty,
                 owner == 1 && s_ack, owner == 1 && s_err, owner == 1 && s_rty};
        check("ctrl",     64'(obs_ctrl()), 64'(ectrl));
        check("s_adr",    64'(s_adr), 64'(eadr));
        check("s_dat_ms", 64'(s_dat_ms), 64'(edat));
        check("sel_cti_bte", 64'({s_sel, s_cti, s_bte}), 64'(emisc));
        check("dat_sm",   64'({m0_dat_sm, m1_dat_sm}), 64'({s_dat_sm, s_dat_sm}));
    endtask

    // round-robin ownership rules applied at the clock edge
    task automatic model_step();
        int nxt;
        if (owner < 0) begin
            if (c[0] && c[1])  nxt = (last == 0) ? 1 : 0;
            else if (c[0])     nxt = 0;
            else if (c[1])     nxt = 1;
            else               nxt = -1;
        end else if (c[owner]) begin
            nxt = owner;
        end else if (c[1 - owner]) begin
            nxt = 1 - owner;
        end else begin
            nxt = -1;
        end
        if (nxt >= 0) last = nxt;
        owner = nxt;
    endtask

    initial begin
        // reset values, with busy-looking master inputs that must not leak through
        drive_quiet();
        sys_rst_n = 1'b0;
        c[0] = 1'b1; st[0] = 1'b1; adr[0] = 32'hDEAD_BEEF; dms[0] = 32'h1234_5678;
        s_ack = 1'b1;
        #13;
        check("rst_ctrl", 64'(obs_ctrl()), 64'd0);
        check("rst_adr",  64'(s_adr), 64'd0);
        check("rst_dat",  64'({s_dat_ms, s_sel, s_cti, s_bte}), 64'd0);

        // reset in the middle of a granted cycle
        do_reset();
        c[0] = 1'b1; st[0] = 1'b1; adr[0] = 32'h100;
        @(negedge sys_clk); #1;
        check("pre_rst_gnt", 64'(gnt), 64'(2'b01));
        check("pre_rst_adr", 64'(s_adr), 64'h100);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_rst", 64'({gnt, s_cyc}), 64'd0);
        c[0] = 1'b0; st[0] = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) begin
            @(negedge sys_clk); #1;
            check("post_rst_idle", 64'({gnt, s_cyc}), 64'd0);
        end

        // tie right after reset: M0 first, then handover without an idle cycle
        do_reset();
        c[0] = 1'b1; st[0] = 1'b1; c[1] = 1'b1; st[1] = 1'b1; we[1] = 1'b1;
        #1 check("tie_idle", 64'(gnt), 64'(2'b00));
        @(negedge sys_clk); #1;
        check("tie_first", 64'({gnt, s_cyc, s_we, m1_ack}), 64'({2'b01, 1'b1, 1'b0, 1'b0}));
        c[0] = 1'b0; st[0] = 1'b0;
        #1 check("tie_release", 64'({gnt, s_cyc}), 64'({2'b01, 1'b0}));
        @(negedge sys_clk); #1;
        check("tie_handover", 64'({gnt, s_cyc, s_we}), 64'({2'b10, 1'b1, 1'b1}));

        // randomized traffic; the first stretch keeps both masters requesting
        do_reset();
        for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
            sat = (cyc_i < 300);
            @(negedge sys_clk);
            for (int x = 0; x < 2; x++) begin
                if (c[x] && beats[x] == 0) begin
                    c[x]   = 1'b0;
                    gap[x] = sat ? 0 : int'($urandom_range(0, 3));
                end else if (!c[x]) begin
                    if (gap[x] > 0) begin
                        gap[x]--;
                    end else if (sat || $urandom_range(0, 2) == 0) begin
                        c[x]     = 1'b1;
                        beats[x] = sat ? 1 : int'($urandom_range(1, 8));
                    end
                end
                st[x]  = c[x] && (sat || $urandom_range(0, 4) != 0);
                we[x]  = 1'($urandom);
                adr[x] = $urandom;
                dms[x] = $urandom;
                sel[x] = DB'($urandom);
                cti[x] = 3'($urandom);
                bte[x] = 2'($urandom);
            end
            exp_stb  = (owner >= 0) && st[owner];
            s_dat_sm = $urandom;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            r = int'($urandom_range(0, 9));
            if (exp_stb) begin
                if (r < 6)       s_ack = 1'b1;
                else if (r == 6) s_err = 1'b1;
                else if (r == 7) s_rty = 1'b1;
            end else if (r == 0) begin
                s_ack = 1'b1;
            end
            #1 model_check();
            if (exp_stb && (s_ack || s_err || s_rty)) beats[owner]--;
            model_step();
        end

`ifdef WSHB_ARB_TIMEOUT_EN
        // hung slave: M0 strobes from cycle 1 and is never answered
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (k == 0) begin
                c[0] = 1'b1; st[0] = 1'b1;
            end
            if (k == 3) begin
                c[1] = 1'b1; st[1] = 1'b1;
            end
            #1;
            if (k >= 1 && k <= 16) begin
                check("tmo_wait", 64'({m0_err, s_cyc, gnt}), 64'({1'b0, 1'b1, 2'b01}));
            end else if (k == 17) begin
                check("tmo_abort", 64'({m0_err, s_cyc, s_stb, gnt, m1_err}),
                      64'({1'b1, 1'b0, 1'b0, 2'b00, 1'b0}));
            end else if (k == 18) begin
                check("tmo_idle", 64'(gnt), 64'(2'b00));
            end else if (k == 19) begin
                check("tmo_next", 64'({gnt, s_cyc}), 64'({2'b10, 1'b1}));
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
